// File: rtl/paper_seq_ctrl.sv
// -----------------------------------------------------------------------------
// paper_seq_ctrl
//
// Purpose:
//   Clocked instruction sequencer for the paper processor. Walks each
//   instruction through FETCH -> DECODE -> EXEC -> WB, owns the program
//   counter, and issues single-cycle enables to the accumulator, the store
//   path and the JNO jump logic. HLT parks the sequencer in HALT until reset.
//
// Ports:
//   pulses        in   system clock, rising-edge active
//   r             in   synchronous active-high reset
//   run           in   start request, sampled only in IDLE
//   instr[AW+1:0] in   instruction at pc: [AW+1:AW] opcode, [AW-1:0] operand
//   sta           in   datapath overflow status, sampled only in EXEC
//   pc            out  program counter / instruction address
//   operand       out  operand address field of the instruction register
//   ir_load       out  instruction-register load strobe (FETCH)
//   acc_load      out  accumulator load strobe (EXEC of ADD)
//   mem_we        out  store strobe (EXEC of STA)
//   enabling      out  JNO check enable (EXEC of JNO)
//   enabling_sta  out  JNO taken enable (enabling & !sta)
//   openpulse     out  jump strobe, pc is loaded from operand in WB
//   busy          out  high in FETCH, DECODE, EXEC and WB
//   halted        out  high in HALT
// -----------------------------------------------------------------------------
module paper_seq_ctrl #(
  parameter int AW = 4
) (
  input  logic          pulses,
  input  logic          r,
  input  logic          run,
  input  logic [AW+1:0] instr,
  input  logic          sta,
  output logic [AW-1:0] pc,
  output logic [AW-1:0] operand,
  output logic          ir_load,
  output logic          acc_load,
  output logic          mem_we,
  output logic          enabling,
  output logic          enabling_sta,
  output logic          openpulse,
  output logic          busy,
  output logic          halted
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_JNO = 2'b01;
  localparam logic [1:0] OP_STA = 2'b10;
  localparam logic [1:0] OP_HLT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t        r_state;
  logic [AW+1:0] r_ir;
  logic [1:0]    r_op;
  logic          r_taken;
  logic [AW-1:0] r_pc;

  logic          w_exec;
  logic          w_jno_exec;

  always_ff @(posedge pulses) begin
    if (r) begin
      r_state <= S_IDLE;
      r_ir    <= '0;
      r_op    <= OP_ADD;
      r_taken <= 1'b0;
      r_pc    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (run) r_state <= S_FETCH;
        end
        S_FETCH: begin
          r_ir    <= instr;
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          r_op    <= r_ir[AW+1:AW];
          r_state <= (r_ir[AW+1:AW] == OP_HLT) ? S_HALT : S_EXEC;
        end
        S_EXEC: begin
          // The jump decision is frozen here so sta may change freely in WB.
          r_taken <= (r_op == OP_JNO) && !sta;
          r_state <= S_WB;
        end
        S_WB: begin
          // Increment wraps naturally at AW bits.
          r_pc    <= r_taken ? r_ir[AW-1:0] : r_pc + 1'b1;
          r_taken <= 1'b0;
          r_state <= S_FETCH;
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Strobes are gated by r so an abandoned instruction emits nothing in the
  // reset cycle itself, not only from the cycle after.
  assign w_exec     = (r_state == S_EXEC) && !r;
  assign w_jno_exec = w_exec && (r_op == OP_JNO);

  assign pc           = r_pc;
  assign operand      = r_ir[AW-1:0];
  assign ir_load      = (r_state == S_FETCH) && !r;
  assign acc_load     = w_exec && (r_op == OP_ADD);
  assign mem_we       = w_exec && (r_op == OP_STA);
  assign enabling     = w_jno_exec;
  assign enabling_sta = w_jno_exec && !sta;
  assign openpulse    = w_jno_exec && !sta;
  assign busy         = !r && ((r_state == S_FETCH) || (r_state == S_DECODE) ||
                               (r_state == S_EXEC)  || (r_state == S_WB));
  assign halted       = !r && (r_state == S_HALT);

endmodule

// File: tb/tb_paper_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_paper_seq_ctrl
//
// Purpose:
//   Directed self-checking bench for paper_seq_ctrl (AW=4). A small program
//   array plays the instruction memory; expected values are hand-derived
//   cycle by cycle, where cycle 0 is the IDLE cycle in which run is sampled.
// -----------------------------------------------------------------------------
module tb_paper_seq_ctrl;

  localparam int AW = 4;

  logic          pulses;
  logic          r;
  logic          run;
  logic [AW+1:0] instr;
  logic          sta;
  logic [AW-1:0] pc;
  logic [AW-1:0] operand;
  logic          ir_load;
  logic          acc_load;
  logic          mem_we;
  logic          enabling;
  logic          enabling_sta;
  logic          openpulse;
  logic          busy;
  logic          halted;

  logic [AW+1:0] prog [16];

  int n_checks;
  int n_errors;

  paper_seq_ctrl #(.AW(AW)) dut (
    .pulses       (pulses),
    .r            (r),
    .run          (run),
    .instr        (instr),
    .sta          (sta),
    .pc           (pc),
    .operand      (operand),
    .ir_load      (ir_load),
    .acc_load     (acc_load),
    .mem_we       (mem_we),
    .enabling     (enabling),
    .enabling_sta (enabling_sta),
    .openpulse    (openpulse),
    .busy         (busy),
    .halted       (halted)
  );

  initial pulses = 1'b0;
  always #5 pulses = ~pulses;

  // Instruction memory read at the current program counter.
  always_comb instr = prog[pc];

  // {ir_load, acc_load, mem_we, enabling, enabling_sta, openpulse, busy, halted}
  logic [7:0] w_outs;
  assign w_outs = {ir_load, acc_load, mem_we, enabling, enabling_sta,
                   openpulse, busy, halted};

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end else begin
      $display("check %s: 0x%0h ok", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge pulses);
    #1;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) prog[i] = 6'b11_0000;
  endtask

  task automatic do_reset();
    r   = 1'b1;
    run = 1'b0;
    tick();
    r   = 1'b0;
  endtask

  // Drive run for one IDLE cycle; after this returns the DUT is in FETCH (cycle 1).
  task automatic start();
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  initial begin
    logic [4:0] exp_st;
    logic [3:0] exp_pc;

    n_checks = 0;
    n_errors = 0;
    r   = 1'b1;
    run = 1'b0;
    sta = 1'b0;
    clear_prog();

    // ---------------- Reset then run, into the ADD/STA/HLT program ----------
    prog[0] = 6'b00_0011;
    prog[1] = 6'b10_0101;
    prog[2] = 6'b11_0000;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("rst_pc_%0d", i), pc, 0);
      chk($sformatf("rst_outs_%0d", i), w_outs, 0);
    end
    r   = 1'b0;
    run = 1'b1;
    #1;
    chk("idle_no_fetch_yet", w_outs, 0);
    // Cycles 1..14: {ir_load, acc_load, mem_we, busy, halted} and pc.
    for (int cyc = 1; cyc <= 14; cyc++) begin
      tick();
      run = 1'b0;
      if (cyc >= 11) run = 1'b1;  // run must not leave HALT
      exp_st[4] = (cyc == 1) || (cyc == 5) || (cyc == 9);
      exp_st[3] = (cyc == 3);
      exp_st[2] = (cyc == 7);
      exp_st[1] = (cyc <= 10);
      exp_st[0] = (cyc >= 11);
      exp_pc    = (cyc <= 4) ? 4'd0 : (cyc <= 8) ? 4'd1 : 4'd2;
      chk($sformatf("prog_st_c%0d", cyc), {ir_load, acc_load, mem_we, busy, halted}, exp_st);
      chk($sformatf("prog_pc_c%0d", cyc), pc, exp_pc);
    end
    chk("prog_operand", operand, 0);
    run = 1'b0;

    // ---------------- JNO taken then JNO not taken with sta toggling -------
    do_reset();
    clear_prog();
    prog[0]  = 6'b01_1010;   // JNO 10
    prog[10] = 6'b01_0011;   // JNO 3
    sta = 1'b1;              // ignored outside EXEC
    start();                 // cycle 1 FETCH
    tick();                  // cycle 2 DECODE
    chk("jt_decode_outs", w_outs, 8'b0000_0010);
    sta = 1'b0;
    tick();                  // cycle 3 EXEC
    #1;
    chk("jt_exec_outs", w_outs, 8'b0001_1110);
    chk("jt_operand", operand, 10);
    tick();                  // cycle 4 WB
    sta = 1'b1;              // change in WB must not undo the jump
    #1;
    chk("jt_wb_outs", w_outs, 8'b0000_0010);
    tick();                  // cycle 5 FETCH
    chk("jt_fetch_pc", pc, 10);
    chk("jt_fetch_ir", ir_load, 1);
    sta = 1'b0;
    tick();                  // DECODE, sta=0 here is ignored
    chk("jn_decode_outs", w_outs, 8'b0000_0010);
    sta = 1'b1;
    tick();                  // EXEC, sta=1 -> not taken
    #1;
    chk("jn_exec_outs", w_outs, 8'b0001_0010);
    tick();                  // WB
    sta = 1'b0;              // change in WB ignored
    #1;
    chk("jn_wb_outs", w_outs, 8'b0000_0010);
    tick();                  // FETCH at 11
    chk("jn_fetch_pc", pc, 11);
    chk("jn_fetch_ir", ir_load, 1);

    // ---------------- Wrap-around: ADD at pc=15 -> pc=0 --------------------
    do_reset();
    clear_prog();
    prog[0]  = 6'b01_1111;   // JNO 15, taken with sta=0
    prog[15] = 6'b00_0000;   // ADD
    sta = 1'b0;
    start();
    for (int i = 0; i < 4; i++) tick();   // now cycle 5, FETCH at 15
    chk("wrap_fetch15_pc", pc, 15);
    tick();
    tick();                               // cycle 7 EXEC of ADD
    chk("wrap_add_outs", w_outs, 8'b0100_0010);
    tick();
    tick();                               // cycle 9 FETCH
    chk("wrap_pc0", pc, 0);
    chk("wrap_fetch_ir", ir_load, 1);

    // ---------------- Reset during EXEC of STA -----------------------------
    do_reset();
    clear_prog();
    prog[0] = 6'b10_0100;    // STA 4
    prog[1] = 6'b10_0100;
    start();
    tick();
    tick();                  // cycle 3 EXEC
    chk("mid_exec_we", mem_we, 1);
    r = 1'b1;
    tick();
    r = 1'b0;
    #1;
    chk("mid_after_rst_outs", w_outs, 0);
    chk("mid_after_rst_pc", pc, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("mid_idle_outs_%0d", i), w_outs, 0);
      chk($sformatf("mid_idle_pc_%0d", i), pc, 0);
    end
    start();
    chk("mid_restart_outs", w_outs, 8'b1000_0010);
    chk("mid_restart_pc", pc, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/paper_seq_ctrl.md
# paper_seq_ctrl

Clocked instruction sequencer for the paper processor. It fetches 2-bit-opcode instructions, decodes them, and issues single-cycle enables to the accumulator, the store path and the JNO jump logic. It replaces free-running delay-timed pulse trains with a synchronous FETCH/DECODE/EXEC/WB state machine. It sits between the instruction memory and the datapath and owns the program counter.

## Interface
Parameters:
- AW, 4, program-counter and operand-address width

Ports (one clock; reset is synchronous and active-high):
- pulses  in  1  system clock, all state updates on rising edge
- r  in  1  synchronous active-high reset
- run  in  1  start request, sampled only in IDLE
- instr  in  2+AW  instruction word from memory at `pc`: [AW+1:AW] opcode, [AW-1:0] operand address
- sta  in  1  overflow status from the datapath, sampled only in EXEC
- pc  out  AW  program counter / instruction address
- operand  out  AW  latched operand address (IR low field)
- ir_load  out  1  instruction-register load strobe
- acc_load  out  1  accumulator load strobe (ADD)
- mem_we  out  1  store strobe (STA)
- enabling  out  1  JNO check enable
- enabling_sta  out  1  JNO taken enable (`enabling & !sta`)
- openpulse  out  1  jump strobe, loads `pc` from operand
- busy  out  1  high in any state except IDLE and HALT
- halted  out  1  high in HALT

## Operation
- Opcodes: 2'b00 ADD, 2'b01 JNO (jump if no overflow), 2'b10 STA, 2'b11 HLT.
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT.
- IDLE:
  - `run`=1 moves to FETCH; otherwise stay.
  - `pc` holds its value.
- FETCH:
  - `ir_load`=1 for this cycle.
  - IR <= `instr` at the clock edge.
  - Go to DECODE.
- DECODE:
  - Latch opcode into the internal exec register.
  - HLT goes to HALT; all other opcodes go to EXEC.
- EXEC:
  - ADD: `acc_load`=1.
  - STA: `mem_we`=1.
  - JNO: `enabling`=1, `enabling_sta`=!sta, `openpulse`=!sta. The taken flag is registered from `sta` at the end of EXEC.
  - Go to WB.
- WB:
  - If JNO was taken: `pc` <= `operand`. Otherwise `pc` <= `pc`+1, modulo 2^AW (wraps from all-ones to 0).
  - Go to FETCH; `run` is not re-sampled.
- HALT:
  - `halted`=1, `pc` frozen.
  - Only `r` exits HALT.
- Strobes are combinational decodes of state plus the registered opcode. At most one of `ir_load`, `acc_load`, `mem_we`, `openpulse` is high in any cycle.
- `operand` is driven continuously from the IR.

## Timing
- Reset (`r`=1 at an edge) forces:
  - state to IDLE
  - `pc`=0 and IR=0
  - all strobes, `busy` and `halted` to 0
- Reset wins over every other event, including mid-instruction; an in-flight instruction is abandoned with no strobes.
- Each non-HLT instruction takes exactly 4 cycles: FETCH, DECODE, EXEC, WB.
- HLT takes 2 cycles, then enters HALT.
- First FETCH occurs on the cycle after `run` is sampled high in IDLE.
- `instr` must be valid during FETCH; `sta` must be valid during EXEC. Changes to `sta` in any other state are ignored.
- JNO to its own address loops every 4 cycles while `sta`=0.
- `pc`=2^AW-1 executing non-taken JNO, ADD or STA gives next FETCH at `pc`=0.
- `busy` is high from FETCH through WB, and low in IDLE and HALT.

## Test plan
- Reset then run: `r`=1 for 2 cycles, then `run`=1 for 1 cycle. Required: `pc`=0 and all outputs 0 during reset; `ir_load`=1 exactly one cycle later; `busy`=1.
- ADD/STA sequence, AW=4, program {00_0011, 10_0101, 11_0000}:
  - `acc_load` on cycle 3.
  - `mem_we` on cycle 7.
  - `pc` values 0,1,2.
  - `halted`=1 after cycle 10; `pc` stays 2.
- JNO taken: instr 01_1010 with `sta`=0 in EXEC. Required: `enabling`=`enabling_sta`=`openpulse`=1 for one cycle; next FETCH at `pc`=10.
- JNO not taken: same instr with `sta`=1. Required: `enabling`=1, `openpulse`=0, `enabling_sta`=0; next `pc`=old+1. Also toggle `sta` in DECODE and WB and check that it has no effect.
- Wrap-around: ADD at `pc`=15 (AW=4) -> next `pc`=0.
- Reset mid-operation: assert `r` during EXEC of STA. Required: `mem_we`=0 on the following cycles; state IDLE; `pc`=0; no restart until `run`.
